// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uarttx transmitter among NUM_REQ byte
// producers. The winner's byte is latched and presented on newd/tx_data;
// a rising donetx completes the frame and acks the winner, and a watchdog
// timer aborts a transfer if the transmitter never finishes.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 newd,
  output logic [7:0]           tx_data,
  input  logic                 donetx,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] owner_next;
  logic [PW-1:0] pick;
  logic [PW:0]   cand;
  logic          hit;
  logic [TW-1:0] timer;
  logic          donetx_q;
  logic          done_rise;
  logic [7:0]    req_byte [NUM_REQ];

  // Split the flat data bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  assign done_rise  = donetx & ~donetx_q;
  assign owner_next = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy       = (state != IDLE);

  // Rotating priority scan: first asserted request at or after ptr, wrapping.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (!hit && req[cand[PW-1:0]]) begin
        hit  = 1'b1;
        pick = cand[PW-1:0];
      end
    end
  end

  // Grant / transmit / release sequencing with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      ack         <= '0;
      grant       <= '0;
      newd        <= 1'b0;
      tx_data     <= 8'h00;
      timeout_err <= 1'b0;
      donetx_q    <= 1'b0;
      timer       <= '0;
    end else begin
      donetx_q    <= donetx;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            owner   <= pick;
            grant   <= ONE_HOT0 << pick;
            tx_data <= req_byte[pick];
            newd    <= 1'b1;
            timer   <= '0;
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A completed frame takes precedence over a coincident timeout.
          if (done_rise) begin
            newd  <= 1'b0;
            ack   <= grant;
            ptr   <= owner_next;
            state <= RELEASE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            newd        <= 1'b0;
            timeout_err <= 1'b1;
            ptr         <= owner_next;
            state       <= RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE: begin
          // Hold ownership until donetx drops so newd is seen low before
          // the transmitter can accept another frame.
          if (!donetx) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: clients hold byte queues, a
// behavioural uarttx stub completes frames, and a monitor compares each
// grant/ack/timeout against expectations pushed when stimulus is issued.
module tb_uart_tx_arbiter;

  localparam int NUM   = 4;
  localparam int TO    = 4096;
  localparam int DEPTH = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [NUM-1:0]  req;
  logic [8*NUM-1:0] req_data;
  logic [NUM-1:0]  ack;
  logic [NUM-1:0]  grant;
  logic            newd;
  logic [7:0]      tx_data;
  logic            donetx;
  logic            busy;
  logic            timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .grant       (grant),
    .newd        (newd),
    .tx_data     (tx_data),
    .donetx      (donetx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         to;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frames_q[$];
  int         acks_expected = 0;
  int         acks_seen = 0;

  logic [7:0] cbuf [NUM][DEPTH];
  int         chead [NUM];
  int         ctail [NUM];
  int         mcur  [NUM];
  int         model_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic push_exp(input int idx, input logic [7:0] data, input bit to);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.to   = to;
    exp_q.push_back(e);
    if (!to) acks_expected++;
  endtask

  task automatic load_byte(input int i, input logic [7:0] d);
    cbuf[i][ctail[i]] = d;
    ctail[i]++;
  endtask

  // Reference: every client with unsent bytes keeps requesting; each
  // decision picks the first such client at or after the pointer, and the
  // pointer moves just past the client served.
  task automatic predict();
    int left [NUM];
    int total;
    int c;
    total = 0;
    for (int i = 0; i < NUM; i++) begin
      left[i] = ctail[i] - mcur[i];
      total  += left[i];
    end
    while (total > 0) begin
      for (int k = 0; k < NUM; k++) begin
        c = (model_ptr + k) % NUM;
        if (left[c] > 0) begin
          push_exp(c, cbuf[c][mcur[c]], 1'b0);
          mcur[c]++;
          left[c]--;
          total--;
          model_ptr = (c + 1) % NUM;
          break;
        end
      end
    end
  endtask

  function automatic bit clients_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NUM; i++) if (chead[i] < ctail[i]) e = 1'b0;
    return e;
  endfunction

  // Client drivers: advance on ack, present the head byte while non-empty.
  always @(negedge clk) begin
    for (int i = 0; i < NUM; i++) begin
      if (ack[i] && chead[i] < ctail[i]) chead[i]++;
      req[i] = (chead[i] < ctail[i]);
      req_data[8*i +: 8] = (chead[i] < ctail[i]) ? cbuf[i][chead[i]] : 8'($urandom);
    end
  end

  // Behavioural uarttx: accepts newd when idle, finishes the frame a random
  // time later, then holds donetx high for a few cycles.
  bit         stub_en = 1'b1;
  bit         stale_force = 1'b0;
  bit         stub_busy = 1'b0;
  int         stub_cnt = 0;
  int         hold_cnt = 0;
  logic [7:0] stub_byte;

  always @(negedge clk) begin
    if (rst) begin
      stub_busy = 1'b0;
      stub_cnt  = 0;
      hold_cnt  = 0;
      donetx    = 1'b0;
    end else if (stale_force) begin
      donetx = 1'b1;
    end else if (!stub_en) begin
      donetx = 1'b0;
    end else if (stub_busy) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        stub_busy = 1'b0;
        donetx    = 1'b1;
        frames_q.push_back(stub_byte);
        hold_cnt  = $urandom_range(4, 1);
      end
    end else if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) donetx = 1'b0;
    end else begin
      donetx = 1'b0;
      if (newd) begin
        stub_busy = 1'b1;
        stub_byte = tx_data;
        stub_cnt  = $urandom_range(30, 12);
      end
    end
  end

  // Monitor: pops the scoreboard on each grant and checks completions.
  bit         have_cur = 1'b0;
  bit         cur_done = 1'b0;
  bit         cur_to = 1'b0;
  int         cur_idx = 0;
  logic [7:0] cur_data = 8'h00;
  int         newd_cycles = 0;
  logic       newd_prev = 1'b0;
  logic       busy_prev = 1'b0;
  exp_t       mon_e;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      have_cur  = 1'b0;
      cur_done  = 1'b0;
      newd_prev = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (newd && !newd_prev) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_grant", $sformatf("grant=%b tx_data=%h with nothing expected", grant, tx_data));
        end else begin
          mon_e = exp_q.pop_front();
          check("grant", grant, 1 << mon_e.idx);
          check("tx_data", tx_data, mon_e.data);
          have_cur    = 1'b1;
          cur_done    = 1'b0;
          cur_idx     = mon_e.idx;
          cur_data    = mon_e.data;
          cur_to      = mon_e.to;
          newd_cycles = 0;
        end
      end
      if (newd) newd_cycles++;
      if (ack != '0) begin
        acks_seen++;
        if (!have_cur || cur_done || cur_to) begin
          fail("ack_unexpected", $sformatf("ack=%b grant=%b", ack, grant));
        end else begin
          check("ack", ack, 1 << cur_idx);
          check("newd_low_at_ack", newd, 0);
          check("tx_data_held", tx_data, cur_data);
          check("grant_at_ack", grant, 1 << cur_idx);
          if (frames_q.size() == 0) fail("frame_missing", $sformatf("ack for %h but no frame sent", cur_data));
          else check("frame_byte", frames_q.pop_front(), cur_data);
          cur_done = 1'b1;
        end
      end
      if (timeout_err) begin
        if (!have_cur || cur_done || !cur_to) begin
          fail("timeout_unexpected", $sformatf("timeout_err with grant=%b", grant));
        end else begin
          check("timeout_latency", newd_cycles, TO);
          check("newd_low_at_timeout", newd, 0);
          check("tx_data_held_to", tx_data, cur_data);
          cur_done = 1'b1;
        end
      end
      if (busy_prev && !busy) begin
        check("donetx_low_at_release", donetx, 0);
        check("grant_cleared", grant, 0);
        if (have_cur && !cur_done) fail("released_early", $sformatf("client %0d released without ack/timeout", cur_idx));
        have_cur = 1'b0;
      end
      newd_prev = newd;
      busy_prev = busy;
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (k < budget && !(exp_q.size() == 0 && !busy && clients_empty())) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) fail("wait_idle_budget", $sformatf("still busy=%b pending=%0d after %0d cycles", busy, exp_q.size(), budget));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_newd(input int budget);
    int k;
    k = 0;
    while (k < budget && !newd) begin
      @(negedge clk);
      k++;
    end
    if (!newd) fail("wait_newd_budget", $sformatf("newd not seen within %0d cycles", budget));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] b [4];
    int         a;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    donetx   = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      chead[i] = 0;
      ctail[i] = 0;
      mcur[i]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_newd", newd, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All four request together, one byte each: served 0,1,2,3.
    for (int i = 0; i < NUM; i++) load_byte(i, 8'($urandom));
    predict();
    wait_idle(2000);

    // Single request from client 1.
    load_byte(1, 8'hA5);
    predict();
    wait_idle(500);

    // Fairness: client 0 streams, client 2 joins mid-frame -> 0,2,0,0.
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    for (int k = 0; k < 4; k++) load_byte(0, b[k]);
    push_exp(0, b[0], 1'b0);
    wait_newd(20);
    repeat (4) @(negedge clk);
    d = 8'($urandom);
    load_byte(2, d);
    push_exp(2, d, 1'b0);
    push_exp(0, b[1], 1'b0);
    push_exp(0, b[2], 1'b0);
    push_exp(0, b[3], 1'b0);
    mcur[0]  += 4;
    mcur[2]  += 1;
    model_ptr = 1;
    wait_idle(2000);

    // Randomized rounds of simultaneous multi-byte requests.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM; i++) begin
        a = $urandom_range(3, 0);
        for (int k = 0; k < a; k++) load_byte(i, 8'($urandom));
      end
      predict();
      wait_idle(5000);
    end

    // Timeout: transmitter never reports done; client drops req after grant.
    stub_en = 1'b0;
    d = 8'($urandom);
    load_byte(2, d);
    push_exp(2, d, 1'b1);
    mcur[2]++;
    model_ptr = 3;
    wait_newd(20);
    repeat (2) @(negedge clk);
    chead[2] = ctail[2];
    mcur[2]  = ctail[2];
    wait_idle(TO + 200);
    stub_en = 1'b1;
    load_byte(0, 8'($urandom));
    load_byte(1, 8'($urandom));
    load_byte(3, 8'($urandom));
    predict();
    wait_idle(2000);

    // Stale donetx high at grant time must not produce an ack.
    stale_force = 1'b1;
    repeat (2) @(negedge clk);
    a = acks_seen;
    load_byte(1, 8'($urandom));
    predict();
    wait_newd(20);
    repeat (10) @(negedge clk);
    check("stale_no_ack", acks_seen, a);
    check("stale_busy", busy, 1);
    check("stale_newd", newd, 1);
    stale_force = 1'b0;
    wait_idle(500);

    // Asynchronous reset mid-frame, then pointer restarts at 0.
    load_byte(2, 8'($urandom));
    predict();
    wait_newd(20);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_newd", newd, 0);
    check("async_rst_grant", grant, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ack", ack, 0);
    check("async_rst_tx_data", tx_data, 0);
    check("async_rst_timeout_err", timeout_err, 0);
    exp_q.delete();
    for (int i = 0; i < NUM; i++) begin
      chead[i] = ctail[i];
      mcur[i]  = ctail[i];
    end
    model_ptr     = 0;
    acks_expected = acks_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    load_byte(1, 8'($urandom));
    load_byte(3, 8'($urandom));
    predict();
    wait_idle(1000);

    check("exp_drained", exp_q.size(), 0);
    check("extra_frames", frames_q.size(), 0);
    check("ack_total", acks_seen, acks_expected);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uarttx transmitter among NUM_REQ byte producers. It latches the winning requester's byte and drives uarttx's newd/tx_data handshake. It detects frame completion from donetx, returns a one-cycle ack to the winner, and recovers from a stalled transmitter with a timeout. It sits between the client logic and uarttx, on the same system clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT_DONE before abort; must exceed one full frame plus the idle uclk period.

Ports:
clk  in  1  system clock (same clock that drives uarttx)
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  level request per requester; one byte per ack
req_data  in  8*NUM_REQ  byte per requester; slice i = [8*i+7:8*i]
ack  out  NUM_REQ  one-cycle pulse to the winner when its byte has been fully sent
grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when free
newd  out  1  to uarttx newd
tx_data  out  8  to uarttx tx_data; latched byte
donetx  in  1  from uarttx donetx
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset is asynchronous, active-high, and clk is the only clock. On reset: state=IDLE, ptr=0, ack=0, grant=0, newd=0, tx_data=8'h00, busy=0, timeout_err=0, donetx_q=0, timer=0.
- donetx is registered once into donetx_q. done_rise = donetx & ~donetx_q.
- States: IDLE, WAIT_DONE, RELEASE.
- IDLE:
  - Scan req starting at index ptr, wrapping N-1 -> 0. Pick the first asserted index g.
  - On a hit, at the next edge: grant=onehot(g), tx_data=req_data slice g, newd=1, timer=0, state goes to WAIT_DONE.
  - Latency from req sampled high to newd high is 1 cycle.
  - With no requests, stay in IDLE.
- WAIT_DONE:
  - newd stays at 1 and tx_data stays stable; uarttx ignores newd during transfer.
  - timer increments each cycle.
  - On done_rise: newd=0, ack[g]=1 for one cycle, ptr=(g+1) mod NUM_REQ, state goes to RELEASE.
  - Else if timer==TIMEOUT_CYCLES-1: newd=0, timeout_err=1 for one cycle, no ack, ptr=(g+1) mod NUM_REQ, state goes to RELEASE.
  - If done_rise and timeout occur in the same cycle, done_rise wins.
- RELEASE:
  - grant is held. Stay here until donetx==0, then grant=0 and state goes to IDLE.
  - This guarantees newd is low at uarttx's next idle uclk edge, so there is no duplicate frame.
  - It also absorbs a donetx that was stale-high when the frame began.
- Requester changes:
  - req is sampled only in IDLE.
  - Dropping req while granted has no effect: the byte is still sent and ack still pulses.
  - Changing req_data after grant has no effect, because tx_data is latched.
  - A requester with more bytes keeps req high and presents the next byte by the cycle after its ack. Otherwise it drops req by that cycle.
- Fairness: after serving g, the lowest priority is g. Each of N continuously requesting clients is served once per N frames.
- Reset during WAIT_DONE or RELEASE clears newd immediately, asynchronously. uarttx's own rst must be asserted alongside.
- timer width is clog2(TIMEOUT_CYCLES). timer never wraps, because it is cleared on entry to WAIT_DONE.

Test Plan:
1. Single request: req=4'b0010, req_data[15:8]=8'hA5 with uarttx attached → 1 cycle later grant=4'b0010, newd=1, tx_data=8'hA5. The tx line shows start, 10100101 LSB-first, stop. On donetx rise: newd=0 and ack[1] pulses once. busy=0 after donetx falls. Exactly one frame is sent.
2. Simultaneous requests: req=4'b1111 held, each client keeps req high for exactly one ack → grants in order 0,1,2,3. Exactly 4 frames are sent, with no frame repeated.
3. Fairness: req[0] held high permanently and req[2] pulsed on once mid-frame of client 0 → service order 0,2,0,0…. Client 2 is served within one frame.
4. Timeout: donetx tied 0, req=4'b0100 → after TIMEOUT_CYCLES=4096 cycles in WAIT_DONE: timeout_err pulses once, newd=0, no ack. The next grant goes to index 3 or wraps.
5. Stale donetx: force donetx=1 at grant time, then release it → no ack until a fresh rising edge. RELEASE waits for donetx low before IDLE.
6. Reset mid-frame: assert rst while in WAIT_DONE → all outputs are 0 asynchronously, before the next clk edge. After release, req=4'b0001 is granted normally and ptr starts at 0.
